// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locked arbiter feeding one UART transmitter,
//               with a per-byte watchdog that aborts stalled packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 8191
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_REQ-1:0]                    req,
    input  logic [8*N_REQ-1:0]                  req_data,
    input  logic [N_REQ-1:0]                    req_last,
    output logic [N_REQ-1:0]                    req_ack,
    output logic                                tx_start,
    output logic [7:0]                          tx_data,
    input  logic                                tx_done,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner,
    output logic                                owner_valid,
    output logic                                timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W:0]   C_N_REQ    = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic               r_owner_valid;
    logic               r_last_flag;
    logic [TMR_W-1:0]   r_timer;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [N_REQ-1:0]   r_req_ack;
    logic               r_timeout_err;

    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any_req;
    logic               w_own_req;
    logic [7:0]         w_own_data;
    logic               w_own_last;
    logic [N_REQ-1:0]   w_own_onehot;
    logic [IDX_W-1:0]   w_owner_next;
    logic               w_tmr_expired;

    // Walk from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_sum       = '0;
        w_grant_idx = '0;
        w_any_req   = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= C_N_REQ) begin
                w_sum = w_sum - C_N_REQ;
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                w_grant_idx = w_sum[IDX_W-1:0];
                w_any_req   = 1'b1;
            end
        end
    end

    always_comb begin
        w_own_req    = 1'b0;
        w_own_data   = 8'h00;
        w_own_last   = 1'b0;
        w_own_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_req       = req[i];
                w_own_data      = req_data[8*i +: 8];
                w_own_last      = req_last[i];
                w_own_onehot[i] = 1'b1;
            end
        end
    end

    assign w_owner_next  = (r_owner == C_LAST_IDX) ? '0 : r_owner + IDX_W'(1);
    assign w_tmr_expired = (r_timer == C_TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_owner_valid <= 1'b0;
            r_last_flag   <= 1'b0;
            r_timer       <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_req_ack     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_req_ack     <= '0;
            r_timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner       <= w_grant_idx;
                        r_owner_valid <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_own_req) begin
                        r_tx_data   <= w_own_data;
                        r_tx_start  <= 1'b1;
                        r_req_ack   <= w_own_onehot;
                        r_last_flag <= w_own_last;
                        r_timer     <= '0;
                        r_state     <= S_WAIT;
                    end else if (w_tmr_expired) begin
                        r_timeout_err <= 1'b1;
                        r_owner_valid <= 1'b0;
                        r_rr_ptr      <= w_owner_next;
                        r_timer       <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                S_WAIT: begin
                    if (tx_done) begin
                        // Restart the watchdog so each byte gets its full budget.
                        r_timer <= '0;
                        if (r_last_flag) begin
                            r_owner_valid <= 1'b0;
                            r_rr_ptr      <= w_owner_next;
                            r_state       <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else if (w_tmr_expired) begin
                        r_timeout_err <= 1'b1;
                        r_owner_valid <= 1'b0;
                        r_rr_ptr      <= w_owner_next;
                        r_timer       <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                default: begin
                    r_owner_valid <= 1'b0;
                    r_timer       <= '0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack     = r_req_ack;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed scoreboard bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;
    localparam int TX_LAT  = 3;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic [1:0]           owner;
    logic                 owner_valid;
    logic                 timeout_err;

    uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .owner       (owner),
        .owner_valid (owner_valid),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic       kind;   // 0 = byte start, 1 = watchdog abort
        logic [1:0] own;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] mem [N_REQ][16];
    int         wr [N_REQ];
    int         rd [N_REQ];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       tx_mute = 1'b0;
    int         tx_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][wr[i] % 16] = {l, d};
        wr[i]++;
    endtask

    task automatic exp_byte(input int o, input logic [7:0] d);
        exp_t e;
        e.kind = 1'b0; e.own = 2'(o); e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_timeout(input int o);
        exp_t e;
        e.kind = 1'b1; e.own = 2'(o); e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    // Requester model: a byte is pending while its FIFO is non-empty.
    initial begin
        req = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N_REQ; i++) begin wr[i] = 0; rd[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ack[i] && rd[i] != wr[i]) rd[i]++;
                req[i]             = (rd[i] != wr[i]);
                req_data[8*i +: 8] = mem[i][rd[i] % 16][7:0];
                req_last[i]        = mem[i][rd[i] % 16][8];
            end
        end
    end

    // Transmitter model: tx_done TX_LAT cycles after each unmuted tx_start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) begin
                tx_cnt = 0;
            end else begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) tx_done = 1'b1;
                end
                if (tx_start && !tx_mute) tx_cnt = TX_LAT;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (tx_start || timeout_err)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_event", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_start) begin
                        chk("sb_kind_start", {31'd0, e.kind}, 0);
                        chk("sb_owner", owner, e.own);
                        chk("sb_data", tx_data, e.data);
                        chk("sb_ack", req_ack, 4'b0001 << e.own);
                        chk("sb_owner_valid", owner_valid, 1);
                    end else begin
                        chk("sb_kind_timeout", {31'd0, e.kind}, 1);
                        chk("sb_to_owner", owner, e.own);
                        chk("sb_to_valid", owner_valid, 0);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!tx_start && n < 200) begin step(); n++; end
        chk(nm, tx_start, 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!tx_done && n < 200) begin step(); n++; end
        chk(nm, tx_done, 1);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || owner_valid) && n < 400) begin step(); n++; end
        chk(nm, {30'd0, exp_q.size() == 0, !owner_valid}, 3);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_tx_start"}, tx_start, 0);
        chk({nm, "_tx_data"}, tx_data, 0);
        chk({nm, "_req_ack"}, req_ack, 0);
        chk({nm, "_owner"}, owner, 0);
        chk({nm, "_owner_valid"}, owner_valid, 0);
        chk({nm, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #1;
        check_zero(nm);
        for (int i = 0; i < N_REQ; i++) rd[i] = wr[i];
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b1;
        step();
        do_reset("reset");

        // Two requesters, grant starts from rr_ptr=0 -> requester 1 then 3.
        push(1, 8'h41, 1'b1);
        push(3, 8'h53, 1'b1);
        exp_byte(1, 8'h41);
        exp_byte(3, 8'h53);
        step();
        chk("lat_owner_valid", owner_valid, 1);
        chk("lat_owner", owner, 1);
        chk("lat_no_start_yet", tx_start, 0);
        step();
        chk("lat_tx_start", tx_start, 1);
        chk("lat_tx_data", tx_data, 8'h41);
        chk("lat_req_ack", req_ack, 4'b0010);
        wait_drain("drain_two_req");

        // Three-byte packet from 0 while 2 waits; back-to-back timing.
        push(0, 8'h10, 1'b0);
        push(0, 8'h20, 1'b0);
        push(0, 8'h30, 1'b1);
        push(2, 8'h77, 1'b1);
        exp_byte(0, 8'h10);
        exp_byte(0, 8'h20);
        exp_byte(0, 8'h30);
        exp_byte(2, 8'h77);
        wait_start("pkt_first_start");
        wait_done("pkt_first_done");
        step();
        chk("b2b_tx_start", tx_start, 1);
        chk("b2b_tx_data", tx_data, 8'h20);
        wait_drain("drain_packet");

        // Owner stalls in LOAD while another requester waits; lock is kept.
        push(0, 8'h11, 1'b0);
        exp_byte(0, 8'h11);
        exp_byte(0, 8'h22);
        exp_byte(1, 8'hB1);
        wait_start("hold_start");
        push(1, 8'hB1, 1'b1);
        repeat (6) step();
        chk("hold_owner_valid", owner_valid, 1);
        chk("hold_owner", owner, 0);
        chk("hold_no_start", tx_start, 0);
        push(0, 8'h22, 1'b1);
        wait_drain("drain_hold");

        // Watchdog abort: rr_ptr=2, so requester 3 wins, then 0 after abort.
        tx_mute = 1'b1;
        push(3, 8'hC3, 1'b1);
        push(0, 8'hC0, 1'b1);
        exp_byte(3, 8'hC3);
        exp_timeout(3);
        exp_byte(0, 8'hC0);
        wait_start("to_start");
        n = 0;
        while (!timeout_err && n < 100) begin step(); n++; end
        chk("to_latency", n, TIMEOUT);
        chk("to_owner_valid", owner_valid, 0);
        tx_mute = 1'b0;
        step();
        chk("to_single_pulse", timeout_err, 0);
        wait_drain("drain_timeout");

        // Reset while WAIT, then a lone requester 2 from rr_ptr=0.
        tx_mute = 1'b1;
        push(1, 8'h99, 1'b1);
        exp_byte(1, 8'h99);
        wait_start("rst_pre_start");
        repeat (3) step();
        do_reset("mid_wait_reset");
        tx_mute = 1'b0;
        push(2, 8'h5A, 1'b1);
        exp_byte(2, 8'h5A);
        step();
        chk("post_rst_owner_valid", owner_valid, 1);
        chk("post_rst_owner", owner, 2);
        step();
        chk("post_rst_tx_start", tx_start, 1);
        chk("post_rst_req_ack", req_ack, 4'b0100);
        wait_drain("drain_post_reset");

        // Four single-byte packets plus a second from 0: order 0,1,2,3,0.
        do_reset("reset2");
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA4, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        exp_byte(0, 8'hA0);
        exp_byte(1, 8'hA1);
        exp_byte(2, 8'hA2);
        exp_byte(3, 8'hA3);
        exp_byte(0, 8'hA4);
        wait_drain("drain_round_robin");

        repeat (4) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
